// File: rtl/debounce_multi.sv
// N-channel push-button debouncer: 2-FF synchroniser, stability filter, press/release
// pulses and an optional auto-repeat strobe per channel. All outputs are registered.
module debounce_multi #(
  parameter int CHANNELS      = 4,
  parameter int STABLE_CYCLES = 1024,
  parameter int REPEAT_EN     = 0,
  parameter int REPEAT_DELAY  = 19000000,
  parameter int REPEAT_PERIOD = 3800000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CHANNELS-1:0] button_in,
  output logic [CHANNELS-1:0] db_out,
  output logic [CHANNELS-1:0] press,
  // "release" is a reserved word, hence the longer name
  output logic [CHANNELS-1:0] release_pulse,
  output logic [CHANNELS-1:0] strobe
);

  localparam int CW   = $clog2(STABLE_CYCLES);
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = $clog2(RMAX);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_LOW,
    ST_DELAY,
    ST_RPT
  } rpt_state_t;

  logic [CHANNELS-1:0] sync_p0, sync_p1;

  // Stage p0/p1: metastability synchroniser
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= button_in;
      sync_p1 <= sync_p0;
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [CW-1:0] cnt;
    logic          db_r, press_r, rel_r;
    logic          accept, rise, fall;

    assign accept = (sync_p1[i] != db_r) && (cnt == CNT_MAX);
    assign rise   = accept && sync_p1[i];
    assign fall   = accept && !sync_p1[i];

    // Stage p2: stability filter; any return to the current level restarts the count
    always_ff @(posedge clk) begin
      if (reset) begin
        cnt     <= '0;
        db_r    <= 1'b0;
        press_r <= 1'b0;
        rel_r   <= 1'b0;
      end else begin
        press_r <= rise;
        rel_r   <= fall;
        if (sync_p1[i] == db_r) begin
          cnt <= '0;
        end else if (cnt == CNT_MAX) begin
          db_r <= sync_p1[i];
          cnt  <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end

    assign db_out[i]        = db_r;
    assign press[i]         = press_r;
    assign release_pulse[i] = rel_r;

    if (REPEAT_EN != 0) begin : g_rpt
      localparam logic [RW-1:0] DELAY_MAX  = RW'(REPEAT_DELAY - 1);
      localparam logic [RW-1:0] PERIOD_MAX = RW'(REPEAT_PERIOD - 1);

      rpt_state_t    state, state_nxt;
      logic [RW-1:0] rcnt, rcnt_nxt;
      logic          strobe_r, strobe_nxt;

      always_ff @(posedge clk) begin
        if (reset) begin
          state    <= ST_LOW;
          rcnt     <= '0;
          strobe_r <= 1'b0;
        end else begin
          state    <= state_nxt;
          rcnt     <= rcnt_nxt;
          strobe_r <= strobe_nxt;
        end
      end

      // A fall wins over a coinciding repeat tick, so the release cycle never strobes
      always_comb begin
        state_nxt  = state;
        rcnt_nxt   = rcnt;
        strobe_nxt = 1'b0;
        case (state)
          ST_LOW: begin
            if (rise) begin
              state_nxt  = ST_DELAY;
              rcnt_nxt   = '0;
              strobe_nxt = 1'b1;
            end
          end
          ST_DELAY: begin
            if (fall) begin
              state_nxt = ST_LOW;
              rcnt_nxt  = '0;
            end else if (rcnt == DELAY_MAX) begin
              state_nxt  = ST_RPT;
              rcnt_nxt   = '0;
              strobe_nxt = 1'b1;
            end else begin
              rcnt_nxt = rcnt + 1'b1;
            end
          end
          ST_RPT: begin
            if (fall) begin
              state_nxt = ST_LOW;
              rcnt_nxt  = '0;
            end else if (rcnt == PERIOD_MAX) begin
              rcnt_nxt   = '0;
              strobe_nxt = 1'b1;
            end else begin
              rcnt_nxt = rcnt + 1'b1;
            end
          end
          default: begin
            state_nxt = ST_LOW;
            rcnt_nxt  = '0;
          end
        endcase
      end

      assign strobe[i] = strobe_r;
    end else begin : g_norpt
      assign strobe[i] = press_r;
    end
  end

endmodule

// File: tb/tb_debounce_multi.sv
// Bench for debounce_multi: directed scenarios plus random button activity, checked
// against a cycle-level behavioural model of the debounce and repeat rules.
module tb_debounce_multi;
  localparam int CH = 2;
  localparam int SC = 4;
  localparam int RD = 10;
  localparam int RP = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic [CH-1:0] button_in;
  logic [CH-1:0] db0, pr0, rl0, st0;
  logic [CH-1:0] db1, pr1, rl1, st1;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  debounce_multi #(
    .CHANNELS(CH), .STABLE_CYCLES(SC), .REPEAT_EN(0),
    .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut_norpt (
    .clk(clk), .reset(reset), .button_in(button_in),
    .db_out(db0), .press(pr0), .release_pulse(rl0), .strobe(st0)
  );

  debounce_multi #(
    .CHANNELS(CH), .STABLE_CYCLES(SC), .REPEAT_EN(1),
    .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut_rpt (
    .clk(clk), .reset(reset), .button_in(button_in),
    .db_out(db1), .press(pr1), .release_pulse(rl1), .strobe(st1)
  );

  // Reference model state
  logic [CH-1:0] m_dly0, m_dly1;
  logic [CH-1:0] m_db, m_press, m_rel, m_strobe;
  int            m_run[CH];
  int            m_age[CH];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // One clock edge of the model: the filter sees the input from two edges ago
  task automatic model_edge();
    logic [CH-1:0] s2;
    s2       = m_dly1;
    m_press  = '0;
    m_rel    = '0;
    m_strobe = '0;
    if (reset) begin
      m_dly0 = '0;
      m_dly1 = '0;
      m_db   = '0;
      for (int c = 0; c < CH; c++) begin
        m_run[c] = 0;
        m_age[c] = -1;
      end
      return;
    end
    for (int c = 0; c < CH; c++) begin
      if (s2[c] == m_db[c]) begin
        m_run[c] = 0;
      end else begin
        m_run[c]++;
        if (m_run[c] == SC) begin
          m_run[c] = 0;
          m_db[c]  = s2[c];
          if (s2[c]) begin
            m_press[c]  = 1'b1;
            m_strobe[c] = 1'b1;
            m_age[c]    = 0;
          end else begin
            m_rel[c] = 1'b1;
            m_age[c] = -1;
          end
        end
      end
      if (!m_press[c] && m_age[c] >= 0) begin
        m_age[c]++;
        if (m_age[c] == RD || (m_age[c] > RD && (m_age[c] - RD) % RP == 0))
          m_strobe[c] = 1'b1;
      end
    end
    m_dly1 = m_dly0;
    m_dly0 = button_in;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_val("db", 32'(db0), 32'(m_db));
    check_val("press", 32'(pr0), 32'(m_press));
    check_val("release", 32'(rl0), 32'(m_rel));
    check_val("strobe_norpt", 32'(st0), 32'(m_press));
    check_val("db_rpt", 32'(db1), 32'(m_db));
    check_val("press_rpt", 32'(pr1), 32'(m_press));
    check_val("release_rpt", 32'(rl1), 32'(m_rel));
    check_val("strobe_rpt", 32'(st1), 32'(m_strobe));
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  int exp_off[$] = '{0, 10, 13, 16, 19, 22, 25, 28, 31, 34, 37, 40};
  int hold[CH];

  initial begin
    reset     = 1'b1;
    button_in = '0;
    m_dly0 = '0; m_dly1 = '0; m_db = '0;
    m_press = '0; m_rel = '0; m_strobe = '0;
    for (int c = 0; c < CH; c++) begin
      m_run[c] = 0;
      m_age[c] = -1;
    end

    // Reset with both buttons held high
    button_in = 2'b11;
    for (int k = 0; k < 3; k++) begin
      step();
      check_val("t1_rst_db", 32'(db0), 32'(0));
      check_val("t1_rst_strobe", 32'(st1), 32'(0));
    end
    reset = 1'b0;
    steps(5);
    check_val("t1_db_early", 32'(db0), 32'(0));
    step();
    check_val("t1_db", 32'(db0), 32'(2'b11));
    check_val("t1_press", 32'(pr0), 32'(2'b11));
    step();
    check_val("t1_press_once", 32'(pr0), 32'(0));

    // Short glitches on ch0 are rejected
    button_in = 2'b00;
    steps(10);
    for (int r = 0; r < 4; r++) begin
      button_in = 2'b01;
      steps(3);
      button_in = 2'b00;
      steps(3);
    end
    steps(4);
    check_val("t2_db", 32'(db0), 32'(0));

    // Clean press then release on ch0
    button_in = 2'b01;
    steps(5);
    check_val("t3_db_early", 32'(db0), 32'(0));
    step();
    check_val("t3_db", 32'(db0), 32'(2'b01));
    check_val("t3_press", 32'(pr0), 32'(2'b01));
    step();
    check_val("t3_press_once", 32'(pr0), 32'(0));
    button_in = 2'b00;
    steps(5);
    check_val("t3_rel_early", 32'(rl0), 32'(0));
    step();
    check_val("t3_release", 32'(rl0), 32'(2'b01));
    check_val("t3_db_low", 32'(db0), 32'(0));
    steps(4);

    // Auto-repeat while held
    button_in = 2'b01;
    steps(5);
    for (int o = 0; o <= 40; o++) begin
      logic exp_s;
      step();
      exp_s = 1'b0;
      foreach (exp_off[j]) if (exp_off[j] == o) exp_s = 1'b1;
      check_val("t4_strobe", 32'(st1[0]), 32'(exp_s));
    end
    button_in = 2'b00;
    steps(5);
    step();
    check_val("t4_release", 32'(rl1[0]), 32'(1));
    check_val("t4_no_strobe", 32'(st1[0]), 32'(0));
    steps(10);

    // Reset in the middle of auto-repeat
    button_in = 2'b01;
    steps(6);
    steps(11);
    reset = 1'b1;
    step();
    check_val("t5_rst_db", 32'(db1), 32'(0));
    check_val("t5_rst_strobe", 32'(st1), 32'(0));
    reset = 1'b0;
    steps(5);
    step();
    check_val("t5_press", 32'(pr1[0]), 32'(1));
    check_val("t5_strobe", 32'(st1[0]), 32'(1));
    steps(9);
    step();
    check_val("t5_first_rpt", 32'(st1[0]), 32'(1));

    // Simultaneous opposite transitions
    button_in = 2'b10;
    steps(12);
    button_in = 2'b01;
    steps(5);
    step();
    check_val("t6_press", 32'(pr0), 32'(2'b01));
    check_val("t6_release", 32'(rl0), 32'(2'b10));

    // Random activity with variable hold lengths and occasional reset
    for (int c = 0; c < CH; c++) hold[c] = 1;
    for (int n = 0; n < 3000; n++) begin
      for (int c = 0; c < CH; c++) begin
        hold[c]--;
        if (hold[c] <= 0) begin
          button_in[c] = $urandom_range(0, 1);
          hold[c] = ($urandom_range(0, 3) == 0) ? $urandom_range(20, 40) : $urandom_range(1, 2 * SC + 2);
        end
      end
      reset = ($urandom_range(0, 499) == 0);
      step();
    end
    reset = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
